// File: rtl/pipe_wb_stage.sv
// MEM/WB writeback register with valid/ready handshake, synchronous flush,
// an optional 2-entry skid buffer and a saturating backpressure counter.
module pipe_wb_stage #(
    parameter int DATA_W = 32,
    parameter int WR_W   = 5,
    parameter int PC_W   = 32,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [DATA_W-1:0] in_wd,
    input  logic [WR_W-1:0]   in_wr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_we,
    output logic [DATA_W-1:0] out_wd,
    output logic [WR_W-1:0]   out_wr,
    output logic [PC_W-1:0]   out_pc,
    output logic [31:0]       stall_cycles
);

    localparam bit USE_SKID = (SKID != 0);

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] wd;
        logic [WR_W-1:0]   wr;
        logic [PC_W-1:0]   pc;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e        state_q, state_d;
    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    entry_t      in_entry;
    logic        ready_q, ready_d;
    logic [31:0] cnt_q, cnt_d;
    logic        in_xfer, out_xfer;

    assign in_entry  = {in_we, in_wd, in_wr, in_pc};
    assign out_valid = (state_q != EMPTY);

    // With the skid buffer, ready comes straight from a flop so the upstream
    // path is cut; without it, ready looks through to the sink.
    assign in_ready  = USE_SKID ? ready_q : (out_ready | ~out_valid);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    assign out_we       = main_q.we & out_valid;
    assign out_wd       = main_q.wd;
    assign out_wr       = main_q.wr;
    assign out_pc       = main_q.pc;
    assign stall_cycles = cnt_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_entry;
                    end else if (in_xfer) begin
                        if (USE_SKID) begin
                            skid_d  = in_entry;
                            state_d = TWO;
                        end else begin
                            main_d = in_entry;
                        end
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Skid slot is occupied exactly in TWO; ready is its registered inverse.
    assign ready_d = (state_d != TWO);
    assign cnt_d   = (out_valid && !out_ready && (cnt_q != 32'hFFFF_FFFF))
                   ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload registers are reset too because out_wd/out_wr/out_pc
            // must read zero after reset, not just be ignored while invalid.
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together
            // from the values sampled before the edge.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
